// File: rtl/rect_pkg.sv
// ============================================================================
//  Module      : rect_pkg
//  Description : Shared frame geometry defaults and frame-controller states.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package rect_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/lut_frame_ctrl_xy_counter.sv
// ============================================================================
//  Module      : xy_counter
//  Description : Raster column/row position counter with row/frame wrap flags.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module xy_counter #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int CW       = $clog2(H_ACTIVE),
    parameter int RW       = $clog2(V_ACTIVE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          at_eol,
    output logic          at_last
);

    assign at_eol  = (col == CW'(H_ACTIVE - 1));
    assign at_last = at_eol && (row == RW'(V_ACTIVE - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (at_eol) begin
                col <= '0;
                row <= at_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lut_frame_ctrl.sv
// ============================================================================
//  Module      : lut_frame_ctrl
//  Description : Frames a LUT word stream into an H x V raster with markers.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module lut_frame_ctrl
    import rect_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int DW       = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        frame_start,
    input  logic                        abort,
    output logic                        lut_start,
    input  logic [DW-1:0]               lt_data,
    input  logic                        lt_valid,
    input  logic                        lt_last,
    output logic                        lt_ready,
    output logic [DW-1:0]               out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_sof,
    output logic                        out_eol,
    output logic                        out_last,
    output logic [$clog2(H_ACTIVE)-1:0] col,
    output logic [$clog2(V_ACTIVE)-1:0] row,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        err_early_last,
    output logic                        err_missing_last
);

    localparam int CW = $clog2(H_ACTIVE);
    localparam int RW = $clog2(V_ACTIVE);

    state_t r_state;

    logic w_stream;
    logic w_beat;
    logic w_abort_act;
    logic w_clear;
    logic w_advance;
    logic w_at_eol;
    logic w_at_last;

    assign w_stream  = (r_state == ST_STREAM);

    // Zero-latency pass-through; the stream is gated off outside STREAM.
    assign lt_ready  = w_stream && out_ready;
    assign out_valid = w_stream && lt_valid;
    assign out_data  = w_stream ? lt_data : '0;

    assign w_beat      = lt_valid && lt_ready;
    assign w_abort_act = abort && (w_stream || (r_state == ST_START));
    assign w_clear     = w_abort_act || (r_state == ST_DONE);
    // An aborted beat still transfers but must not move the position.
    assign w_advance   = w_beat && !abort;

    assign out_sof  = w_stream && (col == '0) && (row == '0);
    assign out_eol  = w_stream && w_at_eol;
    assign out_last = w_stream && w_at_last;

    xy_counter #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .CW       (CW),
        .RW       (RW)
    ) u_xy (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_clear),
        .advance (w_advance),
        .col     (col),
        .row     (row),
        .at_eol  (w_at_eol),
        .at_last (w_at_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            lut_start        <= 1'b0;
            frame_done       <= 1'b0;
            busy             <= 1'b0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
        end else begin
            lut_start  <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_start && !abort) begin
                        r_state          <= ST_START;
                        lut_start        <= 1'b1;
                        busy             <= 1'b1;
                        err_early_last   <= 1'b0;
                        err_missing_last <= 1'b0;
                    end
                end
                ST_START: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        busy    <= 1'b0;
                    end else if (w_beat) begin
                        if (w_at_last) begin
                            r_state    <= ST_DONE;
                            frame_done <= 1'b1;
                            if (!lt_last) begin
                                err_missing_last <= 1'b1;
                            end
                        end else if (lt_last) begin
                            r_state        <= ST_DONE;
                            frame_done     <= 1'b1;
                            err_early_last <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lut_frame_ctrl.sv
// ============================================================================
//  Module      : tb_lut_frame_ctrl
//  Description : Randomised self-checking bench for lut_frame_ctrl (4x3 frame).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lut_frame_ctrl;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int DW = 32;
    localparam int NW = H * V;

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic          abort;
    logic          lut_start;
    logic [DW-1:0] lt_data;
    logic          lt_valid;
    logic          lt_last;
    logic          lt_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_sof;
    logic          out_eol;
    logic          out_last;
    logic [1:0]    col;
    logic [1:0]    row;
    logic          busy;
    logic          frame_done;
    logic          err_early_last;
    logic          err_missing_last;

    lut_frame_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .DW(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .frame_start      (frame_start),
        .abort            (abort),
        .lut_start        (lut_start),
        .lt_data          (lt_data),
        .lt_valid         (lt_valid),
        .lt_last          (lt_last),
        .lt_ready         (lt_ready),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_sof          (out_sof),
        .out_eol          (out_eol),
        .out_last         (out_last),
        .col              (col),
        .row              (row),
        .busy             (busy),
        .frame_done       (frame_done),
        .err_early_last   (err_early_last),
        .err_missing_last (err_missing_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        int            c;
        int            r;
        logic          sof;
        logic          eol;
        logic          last;
    } bview_t;

    typedef struct packed {
        int c;
        int r;
        int idx;
    } stall_t;

    logic [DW-1:0] words [NW];
    bview_t        beats[$];
    int            beat_cyc[$];
    stall_t        stalls[$];
    logic          fs_lut_start;
    logic          st_lut_start;
    logic          err_e_at_start;
    logic          err_m_at_start;
    logic          abort_beat;
    int            done_cyc;
    int            done_cnt;

    // Reference view of beat k of a raster-ordered H x V frame.
    function automatic bview_t model_beat(input int k);
        bview_t b;
        b.data = words[k];
        b.c    = k % H;
        b.r    = k / H;
        b.sof  = (k == 0);
        b.eol  = ((k % H) == H - 1);
        b.last = (k == NW - 1);
        return b;
    endfunction

    // Requests one frame and plays the source/sink; records what it observes.
    task automatic stream_frame(input int last_idx, input int ready_pct,
                                input int valid_pct, input int abort_at,
                                input int max_cyc);
        int     idx;
        int     cyc;
        bit     fin;
        bit     ab;
        bview_t b;
        stall_t s;
        idx = 0; cyc = 0; fin = 0;
        beats.delete(); beat_cyc.delete(); stalls.delete();
        done_cyc = -1; done_cnt = 0; abort_beat = 1'b0;
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        @(posedge clk); #1 frame_start = 1'b1;
        @(negedge clk); fs_lut_start = lut_start;
        @(posedge clk); #1 frame_start = 1'b0;
        @(negedge clk);
        st_lut_start   = lut_start;
        err_e_at_start = err_early_last;
        err_m_at_start = err_missing_last;
        while (!fin && cyc < max_cyc) begin
            @(posedge clk); #1;
            ab = (abort_at >= 0) && (idx == abort_at);
            if (idx < NW) begin
                lt_valid = ab || ($urandom_range(0, 99) < valid_pct);
                lt_data  = words[idx];
                lt_last  = (idx == last_idx);
            end else begin
                lt_valid = 1'b0;
                lt_data  = '0;
                lt_last  = 1'b0;
            end
            out_ready = ab || ($urandom_range(0, 99) < ready_pct);
            abort     = ab;
            @(negedge clk);
            if (frame_done) begin
                done_cnt++;
                done_cyc = cyc;
                fin      = 1;
            end
            if (lt_valid && lt_ready) begin
                if (ab) begin
                    abort_beat = 1'b1;
                end else begin
                    b.data = out_data; b.c = int'(col); b.r = int'(row);
                    b.sof = out_sof; b.eol = out_eol; b.last = out_last;
                    beats.push_back(b);
                    beat_cyc.push_back(cyc);
                end
                idx++;
            end else if (!frame_done && idx < NW) begin
                s.c = int'(col); s.r = int'(row); s.idx = idx;
                stalls.push_back(s);
            end
            if (ab) fin = 1;
            cyc++;
        end
        @(posedge clk); #1;
        lt_valid = 1'b0; lt_last = 1'b0; abort = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_start = 1'b1; lt_valid = 1'b1; lt_last = 1'b1;
        lt_data = $urandom; out_ready = 1'b1; abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, lut_start, frame_done, err_early_last, err_missing_last} !== 5'b0) begin
            failures++;
            $display("FAIL reset_status: got %b want 00000",
                     {busy, lut_start, frame_done, err_early_last, err_missing_last});
        end
        checks++;
        if ({out_valid, lt_ready, out_sof, out_eol, out_last, out_data} !== '0) begin
            failures++;
            $display("FAIL reset_stream: valid/ready/sof/eol/last=%b%b%b%b%b data=%h want all 0",
                     out_valid, lt_ready, out_sof, out_eol, out_last, out_data);
        end
        checks++;
        if ({col, row} !== 4'b0) begin
            failures++;
            $display("FAIL reset_pos: got col=%0d row=%0d want 0/0", col, row);
        end
        #1 rst = 1'b0; frame_start = 1'b0; lt_valid = 1'b0; lt_last = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_basic();
        bview_t e;
        stream_frame(NW - 1, 100, 100, -1, 60);
        checks++;
        if (fs_lut_start !== 1'b0 || st_lut_start !== 1'b1) begin
            failures++;
            $display("FAIL basic_lut_start: got %b,%b want 0,1", fs_lut_start, st_lut_start);
        end
        checks++;
        if (beats.size() != NW) begin
            failures++;
            $display("FAIL basic_beats: got %0d want %0d", beats.size(), NW);
        end
        for (int k = 0; k < beats.size() && k < NW; k++) begin
            e = model_beat(k);
            checks++;
            if (beats[k] !== e) begin
                failures++;
                $display("FAIL basic_beat%0d: got %h want %h", k, beats[k], e);
            end
        end
        checks++;
        if (done_cnt != 1 || beat_cyc.size() == 0 || done_cyc != beat_cyc[beat_cyc.size()-1] + 1) begin
            failures++;
            $display("FAIL basic_done: got cnt=%0d cyc=%0d want cnt=1 one cycle after last beat",
                     done_cnt, done_cyc);
        end
        @(negedge clk);
        checks++;
        if ({busy, err_early_last, err_missing_last} !== 3'b0) begin
            failures++;
            $display("FAIL basic_end: busy/early/missing got %b want 000",
                     {busy, err_early_last, err_missing_last});
        end
    endtask

    task automatic test_stalls();
        bview_t e;
        stream_frame(NW - 1, 50, 70, -1, 400);
        checks++;
        if (beats.size() != NW || done_cnt != 1) begin
            failures++;
            $display("FAIL stall_count: got beats=%0d done=%0d want %0d/1", beats.size(), done_cnt, NW);
        end
        for (int k = 0; k < beats.size() && k < NW; k++) begin
            e = model_beat(k);
            checks++;
            if (beats[k] !== e) begin
                failures++;
                $display("FAIL stall_beat%0d: got %h want %h", k, beats[k], e);
            end
        end
        foreach (stalls[i]) begin
            checks++;
            if (stalls[i].c != stalls[i].idx % H || stalls[i].r != stalls[i].idx / H) begin
                failures++;
                $display("FAIL stall_frozen: got col=%0d row=%0d want %0d/%0d",
                         stalls[i].c, stalls[i].r, stalls[i].idx % H, stalls[i].idx / H);
            end
        end
        checks++;
        if ({err_early_last, err_missing_last} !== 2'b0) begin
            failures++;
            $display("FAIL stall_err: got %b want 00", {err_early_last, err_missing_last});
        end
    endtask

    task automatic test_early_last();
        bview_t e;
        stream_frame(5, 100, 100, -1, 60);
        checks++;
        if (beats.size() != 6 || done_cnt != 1) begin
            failures++;
            $display("FAIL early_count: got beats=%0d done=%0d want 6/1", beats.size(), done_cnt);
        end
        for (int k = 0; k < beats.size() && k < 6; k++) begin
            e = model_beat(k);
            checks++;
            if (beats[k] !== e) begin
                failures++;
                $display("FAIL early_beat%0d: got %h want %h", k, beats[k], e);
            end
        end
        lt_valid = 1'b1; lt_data = words[6];
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({lt_ready, out_valid, err_early_last, err_missing_last} !== 4'b0010) begin
                failures++;
                $display("FAIL early_after: ready/valid/early/missing got %b want 0010",
                         {lt_ready, out_valid, err_early_last, err_missing_last});
            end
        end
        #1 lt_valid = 1'b0;
    endtask

    task automatic test_missing_last();
        stream_frame(-1, 80, 100, -1, 100);
        checks++;
        if (beats.size() != NW || done_cnt != 1) begin
            failures++;
            $display("FAIL missing_count: got beats=%0d done=%0d want %0d/1", beats.size(), done_cnt, NW);
        end
        repeat (2) @(negedge clk);
        checks++;
        if ({err_early_last, err_missing_last} !== 2'b01) begin
            failures++;
            $display("FAIL missing_flag: early/missing got %b want 01", {err_early_last, err_missing_last});
        end
        stream_frame(NW - 1, 100, 100, -1, 60);
        checks++;
        if (err_m_at_start !== 1'b0 || err_missing_last !== 1'b0) begin
            failures++;
            $display("FAIL missing_clear: got start=%b end=%b want 0/0", err_m_at_start, err_missing_last);
        end
    endtask

    task automatic test_abort();
        bview_t e;
        stream_frame(NW - 1, 100, 100, 7, 60);
        checks++;
        if (beats.size() != 7 || abort_beat !== 1'b1 || done_cnt != 0) begin
            failures++;
            $display("FAIL abort_stream: got beats=%0d abort_beat=%b done=%0d want 7/1/0",
                     beats.size(), abort_beat, done_cnt);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, frame_done, col, row} !== 6'b0) begin
                failures++;
                $display("FAIL abort_idle: busy=%b done=%b col=%0d row=%0d want all 0",
                         busy, frame_done, col, row);
            end
        end
        // abort wins over a simultaneous frame_start in IDLE
        #1 abort = 1'b1; frame_start = 1'b1;
        @(posedge clk); #1 abort = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, lut_start} !== 2'b00) begin
            failures++;
            $display("FAIL abort_priority: busy/lut_start got %b want 00", {busy, lut_start});
        end
        stream_frame(NW - 1, 100, 100, -1, 60);
        e = model_beat(0);
        checks++;
        if (beats.size() != NW || beats[0] !== e) begin
            failures++;
            $display("FAIL abort_restart: got %0d beats first=%h want %0d first=%h",
                     beats.size(), beats.size() ? beats[0] : '0, NW, e);
        end
    endtask

    task automatic test_rst_mid();
        int k;
        k = 0;
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            lt_valid = 1'b1; lt_data = $urandom; lt_last = 1'b0; out_ready = 1'b1;
            frame_start = (i == 2);
            @(negedge clk);
            if (lt_ready) k++;
        end
        #1 frame_start = 1'b0;
        @(negedge clk);
        checks++;
        if ({lut_start, busy, out_valid} !== 3'b011 || int'(col) != k % H || int'(row) != k / H) begin
            failures++;
            $display("FAIL fs_ignored: start/busy/valid=%b col=%0d row=%0d want 011 %0d/%0d",
                     {lut_start, busy, out_valid}, col, row, k % H, k / H);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, lut_start, frame_done, out_valid, lt_ready, out_sof, col, row, out_data} !== '0) begin
            failures++;
            $display("FAIL rst_mid: busy=%b valid=%b ready=%b col=%0d row=%0d data=%h want all 0",
                     busy, out_valid, lt_ready, col, row, out_data);
        end
        #1 lt_valid = 1'b0;
        stream_frame(NW - 1, 100, 100, -1, 60);
        checks++;
        if (beats.size() != NW || done_cnt != 1) begin
            failures++;
            $display("FAIL rst_recover: got beats=%0d done=%0d want %0d/1", beats.size(), done_cnt, NW);
        end
    endtask

    initial begin
        rst = 1'b1; frame_start = 1'b0; abort = 1'b0;
        lt_data = '0; lt_valid = 1'b0; lt_last = 1'b0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_stalls();
        test_early_last();
        test_missing_last();
        test_abort();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lut_frame_ctrl.md
LUT_FRAME_CTRL -- requirements
Module: lut_frame_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, pixels (LUT words) per row.
REQ-002 SHALL have parameter V_ACTIVE, 480, rows per frame.
REQ-003 SHALL have parameter DW, 32, LUT word width.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have the frame-control ports: frame_start  in  1  request one frame; abort  in  1  synchronous frame cancel; lut_start  out  1  one-cycle start pulse to the LUT source.
REQ-006 SHALL have the LUT-side stream ports: lt_data  in  DW  LUT word; lt_valid  in  1; lt_last  in  1  source end-of-frame marker; lt_ready  out  1.
REQ-007 SHALL have the consumer-side stream ports: out_data  out  DW; out_valid  out  1; out_ready  in  1; out_sof  out  1  first word of frame; out_eol  out  1  last word of row; out_last  out  1  last word of frame.
REQ-008 SHALL have the position outputs: col  out  clog2(H_ACTIVE)  current column; row  out  clog2(V_ACTIVE)  current row.
REQ-009 SHALL have the status outputs: busy  out  1  not IDLE; frame_done  out  1  one-cycle pulse; err_early_last  out  1  sticky; err_missing_last  out  1  sticky.

Function
REQ-010 SHALL implement the states IDLE, START, STREAM and DONE.
REQ-011 SHALL go IDLE->START on frame_start; frame_start SHALL be ignored outside IDLE.
REQ-012 SHALL assert lut_start exactly during the START cycle, then go to STREAM on the next cycle.
REQ-013 SHALL in STREAM pass the stream combinationally with zero latency: out_valid=lt_valid, lt_ready=out_ready, out_data=lt_data.
REQ-014 SHALL outside STREAM drive lt_ready=0, out_valid=0 and out_data=0.
REQ-015 SHALL define a beat as a cycle with lt_valid&&lt_ready, and SHALL change col/row only on a beat.
REQ-016 SHALL on a beat increment col, or wrap col to 0 and increment row when col==H_ACTIVE-1.
REQ-017 SHALL assert out_sof when col==0 and row==0, out_eol when col==H_ACTIVE-1, and out_last when col==H_ACTIVE-1 and row==V_ACTIVE-1, all qualified by state==STREAM.
REQ-018 SHALL on the final beat (out_last) with lt_last=1 go to DONE with no error.
REQ-019 SHALL on the final beat with lt_last=0 set err_missing_last and go to DONE.
REQ-020 SHALL on a non-final beat with lt_last=1 set err_early_last and go to DONE; the remaining words are not consumed.
REQ-021 SHALL in DONE pulse frame_done for one cycle, clear col/row to 0, and return to IDLE.
REQ-022 SHALL on abort in START or STREAM go to IDLE next cycle, clear col/row, and not pulse frame_done; a beat in the abort cycle SHALL still complete on the stream but SHALL NOT update the counters.
REQ-023 SHALL give abort priority over frame_start in IDLE.
REQ-024 SHALL clear both error flags when a frame_start is accepted, and hold them otherwise.
REQ-025 SHALL drive busy=1 in START, STREAM and DONE.
REQ-026 SHALL hold all state while out_ready=0 or lt_valid=0 (no timeout).

Reset
REQ-027 SHALL on rst put state=IDLE and set col=0, row=0, lut_start=0, frame_done=0, both error flags=0 and busy=0; all stream outputs SHALL then be 0.
REQ-028 SHALL let rst mid-frame override everything and discard the frame silently.

Structure
REQ-029 SHALL take the state encoding and the default H_ACTIVE/V_ACTIVE from a shared package rect_pkg.
REQ-030 SHALL be a single module; a sub-module xy_counter (col/row wrap logic) is optional.

Verification
REQ-031 SHALL cover: H=4,V=3 with a 12-word source with last on word 11 and out_ready=1 -> lut_start 1 cycle after frame_start, 12 beats, sof on beat 0, eol on beats 3,7,11, frame_done 1 cycle after beat 11, no errors.
REQ-032 SHALL cover: random out_ready with 50% stalls -> same 12 words in order, col/row frozen during stalls.
REQ-033 SHALL cover: lt_last on word 5 -> err_early_last=1, 6 beats accepted, frame_done pulse, lt_ready=0 afterward.
REQ-034 SHALL cover: no lt_last on word 11 -> err_missing_last=1, frame_done pulse; next frame_start clears the flag.
REQ-035 SHALL cover: abort after beat 6 -> IDLE next cycle, col=row=0, no frame_done; a following frame restarts at sof.
REQ-036 SHALL cover: rst asserted mid-STREAM -> all outputs at reset values next cycle; frame_start during STREAM is ignored.
